// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, sync polarity and state types for the raster generator.
// step_count is the one definition of "what an axis counter holds after this edge".
package vga_timing_pkg;

  typedef enum logic {
    POL_LOW  = 1'b0,
    POL_HIGH = 1'b1
  } sync_pol_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gen_state_e;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // Half-rate mode: horizontal figures are 640x480 halved, for pix_ce at Clock_25/2.
  localparam int VGA320_H_ACTIVE = 320;
  localparam int VGA320_H_FP     = 8;
  localparam int VGA320_H_SYNC   = 48;
  localparam int VGA320_H_BP     = 24;
  localparam int VGA320_V_ACTIVE = 240;
  localparam int VGA320_V_FP     = 5;
  localparam int VGA320_V_SYNC   = 2;
  localparam int VGA320_V_BP     = 15;

  function automatic int unsigned step_count(input int unsigned count, input logic inc,
                                             input logic clr, input int unsigned total);
    if (clr) return 0;
    if (!inc) return count;
    if (count == total - 1) return 0;
    return count + 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: control inputs into the generator, timing/coordinates out of it.
// master = generator side, slave = pixel pipeline / pin driver side.
interface vga_timing_gen_if #(
  parameter int HW = 10,
  parameter int VW = 10
);
  logic          pix_ce;
  logic          run;
  logic          h_synch;
  logic          v_synch;
  logic          display_en;
  logic [HW-1:0] pixel_count;
  logic [VW-1:0] line_count;
  logic [HW-1:0] pixel_x;
  logic [VW-1:0] pixel_y;
  logic          line_start;
  logic          frame_start;
  logic          vblank;

  modport master (
    input  pix_ce, run,
    output h_synch, v_synch, display_en, pixel_count, line_count,
           pixel_x, pixel_y, line_start, frame_start, vblank
  );

  modport slave (
    output pix_ce, run,
    input  h_synch, v_synch, display_en, pixel_count, line_count,
           pixel_x, pixel_y, line_start, frame_start, vblank
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with a registered sync pulse.
// active is a combinational look-ahead: whether the value loaded on this edge is visible.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int        TOTAL  = 800,
  parameter int        ACTIVE = 640,
  parameter int        FP     = 16,
  parameter int        SYNC   = 96,
  parameter sync_pol_e POL    = POL_LOW,
  localparam int       W      = $clog2(TOTAL)
) (
  input  logic         Clock_25,
  input  logic         Reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync,
  output logic         active
);

  localparam logic [W-1:0] LAST_W       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACTIVE_W     = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START_W = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END_W   = W'(ACTIVE + FP + SYNC);
  localparam logic         ON           = (POL == POL_HIGH);

  logic [W-1:0] r_count;
  logic         r_sync;
  logic [W-1:0] w_next;
  logic         w_sync_next;

  assign w_next      = W'(step_count(32'(r_count), inc, clr, TOTAL));
  assign w_sync_next = !clr && (w_next >= SYNC_START_W) && (w_next < SYNC_END_W);

  always_ff @(posedge Clock_25 or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
      r_sync  <= ~ON;
    end else begin
      r_count <= w_next;
      r_sync  <= w_sync_next ? ON : ~ON;
    end
  end

  assign count  = r_count;
  assign sync   = r_sync;
  assign wrap   = inc && !clr && (r_count == LAST_W);
  assign active = !clr && (w_next < ACTIVE_W);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with pixel clock enable and run/stop control.
// IDLE parks both axes at zero; the first enabled edge out of IDLE starts a fresh frame.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic              Clock_25,
  input  logic              Reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  gen_state_e    r_state;
  gen_state_e    w_state_next;
  logic          w_go;
  logic          w_clr;
  logic          w_start;
  logic          w_h_inc;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_h_sync;
  logic          w_v_sync;
  logic          w_h_active;
  logic          w_v_active;
  logic          w_den_next;
  logic [HW-1:0] w_h_count;
  logic [HW-1:0] w_h_next;
  logic [VW-1:0] w_v_count;
  logic [VW-1:0] w_v_next;

  logic          r_display_en;
  logic          r_line_start;
  logic          r_frame_start;
  logic          r_vblank;
  logic [HW-1:0] r_pixel_x;
  logic [VW-1:0] r_pixel_y;

  assign w_go = vga.pix_ce & vga.run;

  always_ff @(posedge Clock_25 or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Leaving IDLE loads (0,0) without advancing, so the start edge itself shows pixel 0.
  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b1;
    w_start      = 1'b0;
    w_h_inc      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_next = ST_RUN;
          w_clr        = 1'b0;
          w_start      = 1'b1;
        end
      end
      ST_RUN: begin
        if (vga.run) begin
          w_clr   = 1'b0;
          w_h_inc = vga.pix_ce;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .POL   (sync_pol_e'(H_POL))
  ) u_h_counter (
    .Clock_25(Clock_25),
    .Reset   (Reset),
    .inc     (w_h_inc),
    .clr     (w_clr),
    .count   (w_h_count),
    .wrap    (w_h_wrap),
    .sync    (w_h_sync),
    .active  (w_h_active)
  );

  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .POL   (sync_pol_e'(V_POL))
  ) u_v_counter (
    .Clock_25(Clock_25),
    .Reset   (Reset),
    .inc     (w_h_wrap),
    .clr     (w_clr),
    .count   (w_v_count),
    .wrap    (w_v_wrap),
    .sync    (w_v_sync),
    .active  (w_v_active)
  );

  assign w_h_next   = HW'(step_count(32'(w_h_count), w_h_inc, w_clr, H_TOTAL));
  assign w_v_next   = VW'(step_count(32'(w_v_count), w_h_wrap, w_clr, V_TOTAL));
  assign w_den_next = w_h_active & w_v_active;

  // Strobes fire only on the edge that loads a new zero, so a held pix_ce=0 never stretches them.
  always_ff @(posedge Clock_25 or posedge Reset) begin
    if (Reset) begin
      r_display_en  <= 1'b0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_vblank      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_display_en  <= w_den_next;
      r_pixel_x     <= w_den_next ? w_h_next : '0;
      r_pixel_y     <= w_den_next ? w_v_next : '0;
      r_vblank      <= !w_clr && !w_v_active;
      r_line_start  <= w_start | w_h_wrap;
      r_frame_start <= w_start | (w_h_wrap & w_v_wrap);
    end
  end

  assign vga.h_synch     = w_h_sync;
  assign vga.v_synch     = w_v_sync;
  assign vga.pixel_count = w_h_count;
  assign vga.line_count  = w_v_count;
  assign vga.display_en  = r_display_en;
  assign vga.pixel_x     = r_pixel_x;
  assign vga.pixel_y     = r_pixel_y;
  assign vga.vblank      = r_vblank;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;

endmodule
